// File: rtl/types_def.sv
// Shared definitions for the read-return path.
//   r_type            : completion kind delivered by the burst handler (read / write)
//   data_width        : read data width
//   read_entries_log  : log2 of the number of outstanding read tags
//   returner_entry_t  : one reorder-buffer entry (tag state bits plus data)
package types_def;

  localparam int data_width       = 8;
  localparam int read_entries_log = 3;

  typedef enum logic {
    R_READ  = 1'b0,
    R_WRITE = 1'b1
  } r_type;

  typedef struct packed {
    logic                  pending;
    logic                  filled;
    logic [data_width-1:0] data;
  } returner_entry_t;

endpackage

// File: rtl/read_returner.sv
// read_returner: reorder buffer for read completions.
// Read tags are handed out in order; completions arrive out of order from the
// burst handler and are released to the front end strictly in tag order.
// Write completions bypass the buffer as one-cycle acknowledgements.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_req/gnt/index      in-order read tag allocation (gnt is combinational)
//   returner_valid/type/data/index   completion stream from the burst handler
//   out_valid/ready/data/index       in-order read data to the front end (registered)
//   wr_ack_valid/index       write completion pulse (registered)
//   err_unexpected           sticky flag: read return to a non-pending or already-filled tag
module read_returner
  import types_def::*;
#(
  parameter int IDX_W   = read_entries_log,
  parameter int ENTRIES = 2**IDX_W,
  parameter int DATA_W  = data_width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [IDX_W-1:0]  alloc_index,
  input  logic              returner_valid,
  input  r_type             returner_type,
  input  logic [DATA_W-1:0] returner_data,
  input  logic [IDX_W-1:0]  returner_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              wr_ack_valid,
  output logic [IDX_W-1:0]  wr_ack_index,
  output logic              err_unexpected
);

  localparam logic [IDX_W:0] LP_FULL = ENTRIES[IDX_W:0];

  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [IDX_W:0]    r_count;
  logic [ENTRIES-1:0] r_pending;
  logic [ENTRIES-1:0] r_filled;
  logic [DATA_W-1:0] r_mem [ENTRIES];

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_index;
  logic              r_wr_ack_valid;
  logic [IDX_W-1:0]  r_wr_ack_index;
  logic              r_err;

  logic w_alloc_gnt;
  logic w_alloc_fire;
  logic w_rd_ret;
  logic w_wr_ret;
  logic w_ret_ok;
  logic w_load;

  // Grant depends only on the registered count, so a pop in the same cycle
  // never opens a slot early and there is no out_ready -> alloc_gnt path.
  assign w_alloc_gnt  = (r_count != LP_FULL);
  assign w_alloc_fire = alloc_req && w_alloc_gnt;

  assign w_rd_ret = returner_valid && (returner_type == R_READ);
  assign w_wr_ret = returner_valid && (returner_type == R_WRITE);
  assign w_ret_ok = r_pending[returner_index] && !r_filled[returner_index];

  // Head entry moves into the output register when that register is free or
  // being drained this cycle. Uses pre-edge filled[], so no same-cycle bypass.
  assign w_load = (!r_out_valid || out_ready) && r_pending[r_head] && r_filled[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_pending      <= '0;
      r_filled       <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_index    <= '0;
      r_wr_ack_valid <= 1'b0;
      r_wr_ack_index <= '0;
      r_err          <= 1'b0;
    end else begin
      // The alloc, return and load indices never collide in legal operation:
      // a full buffer blocks alloc, and a loaded entry is already filled so a
      // return to it is flagged as unexpected instead of written.
      if (w_alloc_fire) begin
        r_pending[r_tail] <= 1'b1;
        r_filled[r_tail]  <= 1'b0;
        r_tail            <= r_tail + 1'b1;
      end

      if (w_rd_ret) begin
        if (w_ret_ok) r_filled[returner_index] <= 1'b1;
        else          r_err                    <= 1'b1;
      end

      if (w_load) begin
        r_out_data        <= r_mem[r_head];
        r_out_index       <= r_head;
        r_out_valid       <= 1'b1;
        r_pending[r_head] <= 1'b0;
        r_filled[r_head]  <= 1'b0;
        r_head            <= r_head + 1'b1;
      end else if (out_ready && r_out_valid) begin
        r_out_valid <= 1'b0;
      end

      case ({w_alloc_fire, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_wr_ack_valid <= w_wr_ret;
      if (w_wr_ret) r_wr_ack_index <= returner_index;
    end
  end

  // Data storage carries no reset; validity is tracked by pending/filled.
  always_ff @(posedge clk) begin
    if (!rst && w_rd_ret && w_ret_ok) begin
      r_mem[returner_index] <= returner_data;
    end
  end

  assign alloc_gnt      = w_alloc_gnt;
  assign alloc_index    = r_tail;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_index      = r_out_index;
  assign wr_ack_valid   = r_wr_ack_valid;
  assign wr_ack_index   = r_wr_ack_index;
  assign err_unexpected = r_err;

endmodule

// File: tb/tb_read_returner.sv
module tb_read_returner;
  import types_def::*;

  localparam int IDX_W   = read_entries_log;
  localparam int ENTRIES = 2**IDX_W;
  localparam int DATA_W  = data_width;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_req;
  logic              alloc_gnt;
  logic [IDX_W-1:0]  alloc_index;
  logic              returner_valid;
  r_type             returner_type;
  logic [DATA_W-1:0] returner_data;
  logic [IDX_W-1:0]  returner_index;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              wr_ack_valid;
  logic [IDX_W-1:0]  wr_ack_index;
  logic              err_unexpected;

  read_returner #(.IDX_W(IDX_W), .ENTRIES(ENTRIES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_index(alloc_index),
    .returner_valid(returner_valid), .returner_type(returner_type),
    .returner_data(returner_data), .returner_index(returner_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .wr_ack_valid(wr_ack_valid), .wr_ack_index(wr_ack_index),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  // Reference model: every granted read is a sequence number; tags are seq order mod ENTRIES.
  int                n_chk = 0;
  int                n_err = 0;
  int                seq_next = 0;
  int                tail_m = 0;
  int                exp_q[$];     // seqs in allocation order, awaiting output
  int                unret[$];     // seqs allocated but not yet returned
  int                wr_q[$];      // expected write-ack tags
  int                stag[int];
  logic [DATA_W-1:0] sdata[int];
  bit                sret[int];
  bit                err_m = 1'b0;
  int                hs_cnt = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_ret(logic [IDX_W-1:0] idx, logic [DATA_W-1:0] d);
    int found = -1;
    foreach (unret[i]) if (stag[unret[i]] == int'(idx)) found = i;
    if (found < 0) err_m = 1'b1;
    else begin
      sdata[unret[found]] = d;
      sret[unret[found]]  = 1'b1;
      unret.delete(found);
    end
  endtask

  // Drive one cycle of stimulus (called just after a posedge), update model, advance one edge.
  task automatic cyc(bit a, bit rv, r_type rt, logic [DATA_W-1:0] rd, logic [IDX_W-1:0] ri);
    alloc_req      = a;
    returner_valid = rv;
    returner_type  = rt;
    returner_data  = rd;
    returner_index = ri;
    if (rv && rt == R_READ)  model_ret(ri, rd);
    if (rv && rt == R_WRITE) wr_q.push_back(int'(ri));
    if (a && alloc_gnt) begin
      chk("alloc_index", 32'(alloc_index), 32'(tail_m));
      stag[seq_next] = tail_m;
      sret[seq_next] = 1'b0;
      exp_q.push_back(seq_next);
      unret.push_back(seq_next);
      seq_next++;
      tail_m = (tail_m + 1) % ENTRIES;
    end
    @(posedge clk); #1;
    alloc_req      = 1'b0;
    returner_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, R_READ, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_req = 1'b0;
    returner_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); unret.delete(); wr_q.delete();
    tail_m = 0;
    err_m  = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every output handshake and write ack.
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] held_data;
  logic [IDX_W-1:0]  held_idx;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (stall_prev) begin
          chk("hold_data", 32'(out_data), 32'(held_data));
          chk("hold_index", 32'(out_index), 32'(held_idx));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            int s;
            s = exp_q.pop_front();
            chk("out_index", 32'(out_index), 32'(stag[s]));
            chk("out_data", 32'(out_data), 32'(sdata[s]));
            chk("out_before_return", 32'(sret[s]), 32'd1);
            hs_cnt++;
          end
        end
        stall_prev = !out_ready;
        held_data  = out_data;
        held_idx   = out_index;
      end else begin
        if (stall_prev) chk("valid_dropped_under_stall", 32'(out_valid), 32'd1);
        stall_prev = 1'b0;
      end
      if (wr_ack_valid) begin
        if (wr_q.size() == 0) chk("unexpected_wr_ack", 32'(wr_ack_valid), 32'd0);
        else chk("wr_ack_index", 32'(wr_ack_index), 32'(wr_q.pop_front()));
      end
    end
  end

  initial begin
    int last_tag;
    int h0;
    logic [DATA_W-1:0] hd;
    logic [IDX_W-1:0]  hi;

    out_ready = 1'b1;
    returner_type = R_READ;
    returner_data = '0;
    returner_index = '0;
    do_reset();

    // Reset state
    chk("rst_alloc_gnt", 32'(alloc_gnt), 32'd1);
    chk("rst_alloc_index", 32'(alloc_index), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_wr_ack_valid", 32'(wr_ack_valid), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);

    // In-order single read with two-cycle latency
    cyc(1'b1, 1'b0, R_READ, '0, '0);
    cyc(1'b0, 1'b1, R_READ, 8'hA5, 3'd0);
    chk("no_bypass", 32'(out_valid), 32'd0);
    idle(1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_index", 32'(out_index), 32'd0);
    chk("single_data", 32'(out_data), 32'hA5);
    idle(2);

    // Reorder: tags 0,1,2 returned as 2,0,1
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, R_READ, '0, '0);
    cyc(1'b0, 1'b1, R_READ, 8'h22, 3'd2);
    idle(3);
    chk("hol_block", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b1, R_READ, 8'h00, 3'd0);
    cyc(1'b0, 1'b1, R_READ, 8'h11, 3'd1);
    chk("reorder_first_index", 32'(out_index), 32'd0);
    idle(5);
    chk("reorder_drained", 32'(exp_q.size()), 32'd0);

    // Full and wrap
    do_reset();
    repeat (ENTRIES) cyc(1'b1, 1'b0, R_READ, '0, '0);
    chk("full_gnt", 32'(alloc_gnt), 32'd0);
    cyc(1'b1, 1'b0, R_READ, '0, '0);
    chk("full_refused_tail", 32'(alloc_index), 32'd0);
    cyc(1'b0, 1'b1, R_READ, 8'h3C, 3'd0);
    chk("full_gnt_before_load", 32'(alloc_gnt), 32'd0);
    idle(1);
    chk("wrap_gnt", 32'(alloc_gnt), 32'd1);
    chk("wrap_index", 32'(alloc_index), 32'd0);
    for (int t = ENTRIES - 1; t >= 1; t--) cyc(1'b0, 1'b1, R_READ, 8'(t * 3), 3'(t));
    idle(ENTRIES + 2);
    h0 = hs_cnt;
    last_tag = -1;
    for (int k = 0; k < 3 * ENTRIES; k++) begin
      int cur;
      cur = int'(alloc_index);
      cyc(1'b1, last_tag >= 0, R_READ, 8'($urandom), 3'(last_tag < 0 ? 0 : last_tag));
      last_tag = cur;
    end
    chk("throughput", 32'(hs_cnt - h0 >= 3 * ENTRIES - 3), 32'd1);
    cyc(1'b0, 1'b1, R_READ, 8'h5A, 3'(last_tag));
    idle(4);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, R_READ, '0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, R_READ, 8'($urandom), 3'(stag[exp_q[i]]));
    idle(3);
    chk("bp_valid", 32'(out_valid), 32'd1);
    hd = out_data; hi = out_index;
    idle(4);
    chk("bp_data_stable", 32'(out_data), 32'(hd));
    chk("bp_index_stable", 32'(out_index), 32'(hi));
    h0 = hs_cnt;
    out_ready = 1'b1;
    idle(3);
    chk("bp_drain_consecutive", 32'(hs_cnt - h0), 32'd3);
    chk("bp_drained_valid", 32'(out_valid), 32'd0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      bit a, rv;
      r_type rt;
      logic [IDX_W-1:0] ri;
      out_ready = ($urandom_range(0, 3) != 0);
      a  = $urandom_range(0, 1);
      rv = 1'b0; rt = R_READ; ri = '0;
      if ($urandom_range(0, 7) == 0) begin
        rv = 1'b1; rt = R_WRITE; ri = 3'($urandom);
      end else if (unret.size() > 0 && $urandom_range(0, 1)) begin
        rv = 1'b1;
        ri = 3'(stag[unret[$urandom_range(0, unret.size() - 1)]]);
      end
      cyc(a, rv, rt, 8'($urandom), ri);
    end
    out_ready = 1'b1;
    while (unret.size() > 0) cyc(1'b0, 1'b1, R_READ, 8'($urandom), 3'(stag[unret[0]]));
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) idle(1);
    chk("random_drain_timeout", 32'(exp_q.size()), 32'd0);
    chk("random_no_err", 32'(err_unexpected), 32'(err_m));

    // Write ack and unexpected read
    idle(2);
    cyc(1'b0, 1'b1, R_WRITE, 8'hFF, 3'd5);
    chk("wr_ack_valid", 32'(wr_ack_valid), 32'd1);
    chk("wr_ack_idx5", 32'(wr_ack_index), 32'd5);
    chk("wr_no_out", 32'(out_valid), 32'd0);
    idle(1);
    chk("wr_ack_pulse", 32'(wr_ack_valid), 32'd0);
    cyc(1'b0, 1'b1, R_READ, 8'h77, 3'd6);
    chk("err_set", 32'(err_unexpected), 32'(err_m));
    idle(3);
    chk("err_sticky", 32'(err_unexpected), 32'd1);
    chk("err_no_out", 32'(out_valid), 32'd0);
    do_reset();
    chk("err_cleared", 32'(err_unexpected), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
